alu_seq: RTL and testbench

Parametrised sequential ALU for the CPLD CPU family. It holds NREG general registers of W bits. It performs the single-cycle logic, binary and per-nibble BCD operations. It also adds iterative unsigned multiply and divide with a start/busy/done handshake. It sits between the data bus latch and the register write-back path, and exports the A-side operand for address indexing.

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU: register file, single-cycle logic/binary/BCD ops and
// iterative unsigned multiply/divide behind a start/busy/done handshake.
module alu_seq #(
    parameter int W    = 8,
    parameter int NREG = 4,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          RDY,
    input  logic          start,
    input  logic [3:0]    op,
    input  logic [RW-1:0] src,
    input  logic [RW-1:0] rb,
    input  logic [1:0]    bsel,
    input  logic [RW-1:0] dst,
    input  logic          wr,
    input  logic          CI,
    input  logic [W-1:0]  DB_in,
    output logic [W-1:0]  ai_out,
    output logic [W-1:0]  result,
    output logic [W-1:0]  hi,
    output logic          CO,
    output logic          N,
    output logic          Z,
    output logic          V,
    output logic          busy,
    output logic          done
);

    localparam int CW = $clog2(W + 1);
    localparam logic [3:0] OP_PASS = 4'd0, OP_ROL = 4'd1, OP_ROR = 4'd2, OP_ORA = 4'd3,
                           OP_AND  = 4'd4, OP_EOR = 4'd5, OP_ADC = 4'd6, OP_BCD = 4'd7,
                           OP_MUL  = 4'd8, OP_DIV = 4'd9;

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  regs [NREG];
    logic [W-1:0]  m_q;
    logic [W-1:0]  ai, bi;
    logic          accept_mc;

    logic [3:0]    op_q;
    logic [RW-1:0] dst_q;
    logic          wr_q;
    logic [W-1:0]  b_q;
    logic [2*W-1:0] p_q, p_nx;
    logic [W:0]    mul_sum, div_sh;
    logic          div_ge, div0;
    logic [W-1:0]  div_rem;

    logic [W:0]    bin_sum, bcd_sum;
    logic          add_v;
    logic [W-1:0]  sc_res;
    logic          sc_co, sc_v, sc_n, sc_z;

    // Per-nibble decimal adjust; carry ripples from the adjusted nibble.
    function automatic logic [W:0] bcd_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic ci, input logic sub);
        logic [W-1:0] r;
        logic         c;
        logic [4:0]   t;
        r = '0;
        c = ci;
        for (int i = 0; i < W / 4; i++) begin
            t = {1'b0, a[4*i +: 4]} + {1'b0, b[4*i +: 4]} + {4'b0000, c};
            if (sub) begin
                c = t[4];
                r[4*i +: 4] = c ? t[3:0] : t[3:0] + 4'd10;
            end else begin
                c = (t >= 5'd10);
                r[4*i +: 4] = c ? t[3:0] + 4'd6 : t[3:0];
            end
        end
        return {c, r};
    endfunction

    assign ai        = regs[src];
    assign ai_out    = ai;
    assign busy      = (state == RUN);
    assign accept_mc = RDY && start && (state == IDLE) && (op == OP_MUL || op == OP_DIV);
    assign div0      = (b_q == '0);

    always_comb begin
        case (bsel)
            2'd0:    bi = m_q;
            2'd1:    bi = ~m_q;
            2'd2:    bi = CI ? '0 : '1;
            default: bi = regs[rb];
        endcase
    end

    always_comb begin
        bin_sum = {1'b0, ai} + {1'b0, bi} + {{W{1'b0}}, CI};
        bcd_sum = bcd_add(ai, bi, CI, bsel == 2'd1);
        add_v   = (ai[W-1] == bi[W-1]) && (bin_sum[W-1] != ai[W-1]);
        sc_res  = ai;
        sc_co   = CO;
        sc_v    = V;
        case (op)
            OP_PASS: sc_res = ai;
            OP_ROL:  begin sc_res = {ai[W-2:0], CI}; sc_co = ai[W-1]; end
            OP_ROR:  begin sc_res = {CI, ai[W-1:1]}; sc_co = ai[0]; end
            OP_ORA:  sc_res = ai | bi;
            OP_AND:  sc_res = ai & bi;
            OP_EOR:  sc_res = ai ^ bi;
            OP_ADC:  begin sc_res = bin_sum[W-1:0]; sc_co = bin_sum[W]; sc_v = add_v; end
            OP_BCD:  begin sc_res = bcd_sum[W-1:0]; sc_co = bcd_sum[W]; sc_v = add_v; end
            default: sc_res = ai;
        endcase
        // BCD reports N/Z from the unadjusted binary sum
        sc_n = (op == OP_BCD) ? bin_sum[W-1] : sc_res[W-1];
        sc_z = (op == OP_BCD) ? (bin_sum[W-1:0] == '0) : (sc_res == '0);
    end

    always_comb begin
        mul_sum = {1'b0, p_q[2*W-1:W]} + (p_q[0] ? {1'b0, b_q} : '0);
        div_sh  = {p_q[2*W-1:W], p_q[W-1]};
        div_ge  = (div_sh >= {1'b0, b_q});
        div_rem = div_ge ? W'(div_sh - {1'b0, b_q}) : div_sh[W-1:0];
        if (op_q == OP_MUL) p_nx = {mul_sum, p_q[W-1:1]};
        else                p_nx = {div_rem, p_q[W-2:0], div_ge};
    end

    // Iteration datapath: {hi,lo} holds product or {remainder,quotient}
    always_ff @(posedge clk) begin
        if (RDY) begin
            if (accept_mc) begin
                op_q  <= op;
                dst_q <= dst;
                wr_q  <= wr;
                b_q   <= bi;
                p_q   <= {{W{1'b0}}, ai};
            end else if (state == RUN) begin
                p_q <= p_nx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) regs[i] <= '0;
            m_q    <= '0;
            result <= '0;
            hi     <= '0;
            CO     <= 1'b0;
            N      <= 1'b0;
            Z      <= 1'b0;
            V      <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            done   <= 1'b0;
        end else if (RDY) begin
            m_q  <= DB_in;
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (op == OP_MUL || op == OP_DIV) begin
                            state <= RUN;
                            cnt   <= '0;
                        end else begin
                            done <= 1'b1;
                            if (op <= OP_BCD) begin
                                result <= sc_res;
                                CO     <= sc_co;
                                V      <= sc_v;
                                N      <= sc_n;
                                Z      <= sc_z;
                                if (wr) regs[dst] <= sc_res;
                            end
                        end
                    end
                end
                default: begin
                    cnt <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) begin
                        state  <= IDLE;
                        done   <= 1'b1;
                        result <= p_nx[W-1:0];
                        hi     <= p_nx[2*W-1:W];
                        if (op_q == OP_MUL) begin
                            N  <= p_nx[2*W-1];
                            Z  <= (p_nx == '0);
                            CO <= |p_nx[2*W-1:W];
                            V  <= 1'b0;
                        end else begin
                            N  <= p_nx[W-1];
                            Z  <= !div0 && (p_nx[W-1:0] == '0);
                            CO <= 1'b0;
                            V  <= div0;
                        end
                        if (wr_q) regs[dst_q] <= p_nx[W-1:0];
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: an 8-bit/4-register and a 16-bit/8-register instance,
// expected results queued at issue and compared when done is seen.
module tb_alu_seq;

    typedef struct packed {
        logic [15:0] res;
        logic [15:0] hi;
        logic [3:0]  f;   // {CO,N,Z,V}
    } exp_t;

    localparam logic [3:0] PASS = 4'd0, ROL = 4'd1, ROR = 4'd2, ORA = 4'd3, ANDOP = 4'd4,
                           ADC = 4'd6, BCD = 4'd7, MUL = 4'd8, DIV = 4'd9, NOP = 4'd12;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    exp_t e, o;

    logic clk = 1'b0;
    logic rst_n, rdy;

    logic       start8, wr8, ci8;
    logic [3:0] op8;
    logic [1:0] src8, rb8, bsel8, dst8;
    logic [7:0] db8, ai8, res8, hi8;
    logic       co8, n8, z8, v8, busy8, done8;

    logic        start16, wr16, ci16;
    logic [3:0]  op16;
    logic [2:0]  src16, rb16, dst16;
    logic [1:0]  bsel16;
    logic [15:0] db16, ai16, res16, hi16;
    logic        co16, n16, z16, v16, busy16, done16;

    alu_seq #(.W(8), .NREG(4)) u8 (
        .clk(clk), .rst_n(rst_n), .RDY(rdy), .start(start8), .op(op8), .src(src8),
        .rb(rb8), .bsel(bsel8), .dst(dst8), .wr(wr8), .CI(ci8), .DB_in(db8),
        .ai_out(ai8), .result(res8), .hi(hi8), .CO(co8), .N(n8), .Z(z8), .V(v8),
        .busy(busy8), .done(done8));

    alu_seq #(.W(16), .NREG(8)) u16 (
        .clk(clk), .rst_n(rst_n), .RDY(rdy), .start(start16), .op(op16), .src(src16),
        .rb(rb16), .bsel(bsel16), .dst(dst16), .wr(wr16), .CI(ci16), .DB_in(db16),
        .ai_out(ai16), .result(res16), .hi(hi16), .CO(co16), .N(n16), .Z(z16), .V(v16),
        .busy(busy16), .done(done16));

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic exp_t obs8();
        return {8'h00, res8, 8'h00, hi8, co8, n8, z8, v8};
    endfunction

    function automatic exp_t obs16();
        return {res16, hi16, co16, n16, z16, v16};
    endfunction

    task automatic issue8(input logic [3:0] o_, input logic [1:0] s, input logic [1:0] r,
                          input logic [1:0] b, input logic [1:0] d, input logic w, input logic c);
        op8 = o_; src8 = s; rb8 = r; bsel8 = b; dst8 = d; wr8 = w; ci8 = c; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
    endtask

    task automatic issue16(input logic [3:0] o_, input logic [2:0] s, input logic [1:0] b,
                           input logic [2:0] d, input logic w, input logic c);
        op16 = o_; src16 = s; rb16 = 3'd0; bsel16 = b; dst16 = d; wr16 = w; ci16 = c; start16 = 1'b1;
        @(negedge clk);
        start16 = 1'b0;
    endtask

    // Register load: clear via AND with zero operand, then OR in M.
    task automatic load8(input logic [1:0] d, input logic [7:0] val);
        db8 = val;
        @(negedge clk);
        issue8(ANDOP, d, 2'd0, 2'd2, d, 1'b1, 1'b1);
        issue8(ORA, d, 2'd0, 2'd0, d, 1'b1, 1'b0);
    endtask

    task automatic load16(input logic [2:0] d, input logic [15:0] val);
        db16 = val;
        @(negedge clk);
        issue16(ANDOP, d, 2'd2, d, 1'b1, 1'b1);
        issue16(ORA, d, 2'd0, d, 1'b1, 1'b0);
    endtask

    task automatic wait_done8(output int n);
        n = 0;
        while (!done8 && n < 60) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (obs8() !== '0) begin failures++; $display("FAIL reset8_regs: got %h want 0", obs8()); end
        checks++;
        if ({busy8, done8} !== 2'b00) begin failures++; $display("FAIL reset8_hs: got %b want 00", {busy8, done8}); end
        checks++;
        if (obs16() !== '0 || {busy16, done16} !== 2'b00) begin
            failures++; $display("FAIL reset16: got %h %b want 0", obs16(), {busy16, done16});
        end
        for (int i = 0; i < 4; i++) begin
            src8 = 2'(i);
            #1;
            checks++;
            if (ai8 !== 8'h00) begin failures++; $display("FAIL reset_reg%0d: got %h want 00", i, ai8); end
        end
    endtask

    task automatic test_adc();
        load8(2'd0, 8'h50);
        sb.push_back({16'h00A0, 16'h0000, 4'b0101});
        issue8(ADC, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
        checks++;
        if (done8 !== 1'b1 || busy8 !== 1'b0) begin failures++; $display("FAIL adc_done: got done=%b busy=%b want 1 0", done8, busy8); end
        e = sb.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin failures++; $display("FAIL adc_result: got %h want %h", o, e); end
        src8 = 2'd1;
        #1;
        checks++;
        if (ai8 !== 8'hA0) begin failures++; $display("FAIL adc_wb: got %h want a0", ai8); end
        sb.push_back({16'h00F1, 16'h0000, 4'b0100});
        issue8(ADC, 2'd1, 2'd0, 2'd3, 2'd2, 1'b1, 1'b1);
        e = sb.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin failures++; $display("FAIL adc_regb: got %h want %h", o, e); end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin failures++; $display("FAIL done_clear: got %b want 0", done8); end
    endtask

    task automatic test_bcd();
        logic [7:0] a[3] = '{8'h19, 8'h99, 8'h40};
        logic [7:0] b[3] = '{8'h28, 8'h01, 8'h01};
        logic [1:0] bs[3] = '{2'd0, 2'd0, 2'd1};
        logic       c[3] = '{1'b0, 1'b0, 1'b1};
        exp_t       x[3] = '{{16'h0047, 16'h0000, 4'b0000},
                             {16'h0000, 16'h0000, 4'b1100},
                             {16'h0039, 16'h0000, 4'b1000}};
        for (int i = 0; i < 3; i++) begin
            load8(2'd0, a[i]);
            db8 = b[i];
            @(negedge clk);
            sb.push_back(x[i]);
            issue8(BCD, 2'd0, 2'd0, bs[i], 2'd1, 1'b1, c[i]);
            e = sb.pop_front(); o = obs8();
            checks++;
            if (o !== e || done8 !== 1'b1) begin
                failures++; $display("FAIL bcd_%0d: got %h done=%b want %h done=1", i, o, done8, e);
            end
        end
    endtask

    task automatic test_mul();
        int n, bc;
        load8(2'd0, 8'hFF);
        db8 = 8'hFF;
        @(negedge clk);
        sb.push_back({16'h0001, 16'h00FE, 4'b1100});
        issue8(MUL, 2'd0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
        bc = busy8 ? 1 : 0;
        issue8(ADC, 2'd0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0);
        n = 1;
        bc += busy8 ? 1 : 0;
        while (!done8 && n < 60) begin
            @(negedge clk);
            n++;
            bc += busy8 ? 1 : 0;
        end
        checks++;
        if (n !== 8) begin failures++; $display("FAIL mul_latency: got %0d want 8", n); end
        checks++;
        if (bc !== 8 || busy8 !== 1'b0) begin failures++; $display("FAIL mul_busy: got %0d cycles busy=%b want 8 0", bc, busy8); end
        e = sb.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin failures++; $display("FAIL mul_result: got %h want %h", o, e); end
        src8 = 2'd2;
        #1;
        checks++;
        if (ai8 !== 8'h01) begin failures++; $display("FAIL mul_wb: got %h want 01", ai8); end
        src8 = 2'd3;
        #1;
        checks++;
        if (ai8 !== 8'h00) begin failures++; $display("FAIL start_while_busy: got %h want 00", ai8); end
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin failures++; $display("FAIL mul_extra_done: got %b want 0", done8); end
    endtask

    task automatic test_div();
        int n;
        logic [7:0] b[2] = '{8'h07, 8'h00};
        exp_t x[2] = '{{16'h001C, 16'h0004, 4'b0000}, {16'h00FF, 16'h00C8, 4'b0101}};
        for (int i = 0; i < 2; i++) begin
            load8(2'd0, 8'hC8);
            db8 = b[i];
            @(negedge clk);
            sb.push_back(x[i]);
            issue8(DIV, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
            wait_done8(n);
            e = sb.pop_front(); o = obs8();
            checks++;
            if (n !== 8 || o !== e) begin failures++; $display("FAIL div_%0d: got %h after %0d want %h after 8", i, o, n, e); end
            src8 = 2'd1;
            #1;
            checks++;
            if (ai8 !== x[i].res[7:0]) begin failures++; $display("FAIL div_wb_%0d: got %h want %h", i, ai8, x[i].res[7:0]); end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        load8(2'd0, 8'h0C);
        db8 = 8'h0A;
        @(negedge clk);
        sb.push_back({16'h0078, 16'h0000, 4'b0000});
        issue8(MUL, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
        wait_done8(n);
        e = sb.pop_front(); o = obs8();
        checks++;
        if (n !== 8 || o !== e) begin failures++; $display("FAIL b2b_mul: got %h after %0d want %h after 8", o, n, e); end
        sb.push_back({16'h000C, 16'h0000, 4'b0000});
        issue8(PASS, 2'd0, 2'd0, 2'd0, 2'd2, 1'b1, 1'b0);
        e = sb.pop_front(); o = obs8();
        checks++;
        if (done8 !== 1'b1 || o !== e) begin failures++; $display("FAIL b2b_pass: got %h done=%b want %h done=1", o, done8, e); end
    endtask

    task automatic test_rdy_stall();
        int n;
        load8(2'd0, 8'h0D);
        db8 = 8'h0B;
        @(negedge clk);
        sb.push_back({16'h008F, 16'h0000, 4'b0000});
        issue8(MUL, 2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 1'b0);
        n = 0;
        repeat (3) begin @(negedge clk); n++; end
        rdy = 1'b0;
        repeat (3) begin @(negedge clk); n++; end
        rdy = 1'b1;
        while (!done8 && n < 60) begin @(negedge clk); n++; end
        checks++;
        if (n !== 11) begin failures++; $display("FAIL stall_latency: got %0d want 11", n); end
        e = sb.pop_front(); o = obs8();
        checks++;
        if (o !== e) begin failures++; $display("FAIL stall_result: got %h want %h", o, e); end
        rdy = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (done8 !== 1'b1) begin failures++; $display("FAIL done_hold: got %b want 1", done8); end
        rdy = 1'b1;
        @(negedge clk);
        checks++;
        if (done8 !== 1'b0) begin failures++; $display("FAIL done_release: got %b want 0", done8); end
    endtask

    task automatic test_nop();
        sb.push_back({16'h008F, 16'h0000, 4'b0000});
        issue8(NOP, 2'd0, 2'd0, 2'd0, 2'd0, 1'b1, 1'b0);
        e = sb.pop_front(); o = obs8();
        checks++;
        if (done8 !== 1'b1 || o !== e) begin failures++; $display("FAIL nop: got %h done=%b want %h done=1", o, done8, e); end
        src8 = 2'd0;
        #1;
        checks++;
        if (ai8 !== 8'h0D) begin failures++; $display("FAIL nop_nowrite: got %h want 0d", ai8); end
    endtask

    task automatic test_reset_mid_div();
        int dn;
        load8(2'd0, 8'hC8);
        db8 = 8'h07;
        @(negedge clk);
        issue8(DIV, 2'd0, 2'd0, 2'd0, 2'd3, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy8 !== 1'b0 || done8 !== 1'b0 || obs8() !== '0) begin
            failures++; $display("FAIL reset_abort: got busy=%b done=%b %h want 0 0 0", busy8, done8, obs8());
        end
        @(negedge clk);
        rst_n = 1'b1;
        dn = 0;
        repeat (12) begin @(negedge clk); dn += done8 ? 1 : 0; end
        checks++;
        if (dn !== 0) begin failures++; $display("FAIL reset_nodone: got %0d pulses want 0", dn); end
        src8 = 2'd3;
        #1;
        checks++;
        if (ai8 !== 8'h00) begin failures++; $display("FAIL reset_nowb: got %h want 00", ai8); end
    endtask

    task automatic test_rotate16();
        load16(3'd0, 16'h8001);
        sb.push_back({16'h0002, 16'h0000, 4'b1000});
        issue16(ROL, 3'd0, 2'd0, 3'd1, 1'b1, 1'b0);
        e = sb.pop_front(); o = obs16();
        checks++;
        if (done16 !== 1'b1 || o !== e) begin failures++; $display("FAIL rol16: got %h done=%b want %h done=1", o, done16, e); end
        load16(3'd2, 16'h0001);
        sb.push_back({16'h8000, 16'h0000, 4'b1100});
        issue16(ROR, 3'd2, 2'd0, 3'd7, 1'b1, 1'b1);
        e = sb.pop_front(); o = obs16();
        checks++;
        if (o !== e) begin failures++; $display("FAIL ror16: got %h want %h", o, e); end
        src16 = 3'd7;
        #1;
        checks++;
        if (ai16 !== 16'h8000) begin failures++; $display("FAIL ai16_reg7: got %h want 8000", ai16); end
    endtask

    initial begin
        rst_n = 1'b0; rdy = 1'b1;
        start8 = 1'b0; op8 = '0; src8 = '0; rb8 = '0; bsel8 = '0; dst8 = '0; wr8 = 1'b0; ci8 = 1'b0; db8 = '0;
        start16 = 1'b0; op16 = '0; src16 = '0; rb16 = '0; bsel16 = '0; dst16 = '0; wr16 = 1'b0; ci16 = 1'b0; db16 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_adc();
        test_bcd();
        test_mul();
        test_div();
        test_back_to_back();
        test_rdy_stall();
        test_nop();
        test_reset_mid_div();
        test_rotate16();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
